mu0_control_unit: RTL and testbench
===================================

// Module: mu0_control_unit
// PURPOSE
//  MU0 control FSM. Sequences fetch/execute, drives the datapath mux selects
//  (address mux, ALU A/B muxes), register clock-enables, ALU function and the
//  memory request handshake. Sits between the IR/flag outputs and the
//  mux/ALU/register datapath. Memory may insert wait states. A watchdog faults
//  a hung memory access.
// PARAMETERS
//  TIMEOUT  15  max wait cycles per access before FAULT (>=1); counter width $clog2(TIMEOUT+1)
// PORTS
//  clk        in   1   system clock, rising edge
//  rst_n      in   1   synchronous, active-low reset
//  ir_opcode  in   4   IR[15:12], valid in EXEC
//  acc_zero   in   1   ACC == 0
//  acc_neg    in   1   ACC[15]
//  mem_ready  in   1   memory completes current access this cycle
//  mem_req    out  1   memory access request
//  mem_rnw    out  1   1=read, 0=write
//  addr_sel   out  1   address mux: 0=PC, 1=IR[11:0]
//  alu_a_sel  out  1   ALU A mux: 0=ACC, 1=PC
//  alu_b_sel  out  1   ALU B mux: 0=mem data, 1=IR[11:0]
//  alu_fn     out  2   00 PASS_B, 01 ADD, 10 SUB, 11 INC_A
//  acc_ce     out  1   ACC load enable
//  pc_ce      out  1   PC load enable
//  ir_ce      out  1   IR load enable
//  acc_oe     out  1   ACC drives write data
//  halted     out  1   in HALT
//  fault      out  1   in FAULT (memory timeout)
// BEHAVIOUR
//  - States FETCH, EXEC, HALT, FAULT. The reset edge (rst_n=0) forces FETCH and
//    clears wait_cnt. While rst_n=0, all outputs are 0. Reset mid-access
//    drops mem_req on the next edge.
//  - Outputs are combinational from state, ir_opcode, flags and mem_ready.
//    acc_ce/pc_ce/ir_ce assert only in the completing cycle.
//  - FETCH: mem_req=1, rnw=1, addr_sel=0, alu_a_sel=1, alu_fn=INC_A.
//    If mem_ready=1: ir_ce=1, pc_ce=1, go to EXEC. Otherwise stay in FETCH.
//  - EXEC, decoded by ir_opcode:
//     0 LDA: rd, addr_sel=1, b=mem, PASS_B, acc_ce on ready
//     1 STO: wr (rnw=0), addr_sel=1, acc_oe=1; done on ready
//     2 ADD / 3 SUB: rd, addr_sel=1, a=ACC, b=mem, ADD/SUB, acc_ce on ready
//     4 JMP: no mem_req, b=IR, PASS_B, pc_ce=1; 1 cycle
//     5 JGE: as JMP, pc_ce=!acc_neg
//     6 JNE: as JMP, pc_ce=!acc_zero
//     7 STP: no enables, go to HALT
//     8-F: NOP, 1 cycle, no enables
//    A memory op stays in EXEC until ready. A non-memory op is 1 cycle.
//    EXEC always returns to FETCH except STP.
//  - Best case: 2 cycles per instruction. Each wait state adds 1 cycle.
//  - wait_cnt counts consecutive cycles with mem_req=1 and mem_ready=0. It
//    clears on ready or on any state change.
//    If wait_cnt==TIMEOUT and mem_ready=0, go to FAULT. If ready arrives in
//    that same cycle, ready wins and the access completes normally.
//  - HALT and FAULT are sticky until reset. All enables and mem_req are 0.
//    halted=1 or fault=1 respectively.
//  - mem_rnw=1 whenever mem_req=0. addr_sel/alu selects are 0 when unused.
// STRUCTURE
//  - mu0_pkg: opcode localparams (OP_LDA..OP_STP), ALU_FN encodings, state
//    encoding. Shared with the ALU and the bench.
//  - Sub-module mu0_wait_timer: counter with clear/inc and expired output,
//    parameterised by TIMEOUT.
//  - Next-state and output logic live in the top module.
// TESTING
//  1 Reset: hold rst_n=0 for 3 clk, then release with mem_ready=1 -> first
//    cycle in FETCH: mem_req=1, addr_sel=0, ir_ce=1, pc_ce=1.
//  2 Program LDA/ADD/STO/STP, zero wait states -> 2 cycles each, then
//    halted=1. During STO: acc_oe=1, mem_rnw=0.
//  3 JGE with acc_neg=1 -> pc_ce=0. JNE with acc_zero=0 -> pc_ce=1.
//    Both take 1 EXEC cycle with mem_req=0.
//  4 LDA with mem_ready low for 3 cycles -> 3 extra EXEC cycles, acc_ce only
//    in the 4th EXEC cycle.
//  5 TIMEOUT=15, ready never asserted -> fault=1 after 16 FETCH cycles.
//    Ready on the 16th cycle -> normal completion, no fault.
//  6 rst_n=0 during a waiting LDA -> mem_req=0 next cycle, restarts in FETCH.
//    Opcode 0xA -> NOP, 1 cycle, no enables.

Source files
------------

// File: rtl/mu0_pkg.sv
// Shared MU0 encodings: opcodes, ALU functions, control FSM states and the
// control-signal bundle the sequencer produces each cycle.
package mu0_pkg;

   localparam logic [3:0] OP_LDA = 4'h0;
   localparam logic [3:0] OP_STO = 4'h1;
   localparam logic [3:0] OP_ADD = 4'h2;
   localparam logic [3:0] OP_SUB = 4'h3;
   localparam logic [3:0] OP_JMP = 4'h4;
   localparam logic [3:0] OP_JGE = 4'h5;
   localparam logic [3:0] OP_JNE = 4'h6;
   localparam logic [3:0] OP_STP = 4'h7;

   localparam logic [1:0] ALU_PASS_B = 2'b00;
   localparam logic [1:0] ALU_ADD    = 2'b01;
   localparam logic [1:0] ALU_SUB    = 2'b10;
   localparam logic [1:0] ALU_INC_A  = 2'b11;

   localparam logic [1:0] ST_FETCH = 2'd0;
   localparam logic [1:0] ST_EXEC  = 2'd1;
   localparam logic [1:0] ST_HALT  = 2'd2;
   localparam logic [1:0] ST_FAULT = 2'd3;

   typedef struct packed {
      logic       mem_req;
      logic       mem_rnw;
      logic       addr_sel;
      logic       alu_a_sel;
      logic       alu_b_sel;
      logic [1:0] alu_fn;
      logic       acc_ce;
      logic       pc_ce;
      logic       ir_ce;
      logic       acc_oe;
      logic       halted;
      logic       fault;
   } ctl_t;

endpackage

// File: rtl/mu0_wait_timer.sv
// Counts consecutive memory wait cycles; expired flags that the count has
// reached TIMEOUT so the sequencer can abandon the access.
module mu0_wait_timer #(
   parameter int TIMEOUT = 15
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic inc,
   output logic expired
);

   localparam int W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [W-1:0] LIMIT = W'(TIMEOUT);

   logic [W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!rst_n || clr) begin
         cnt <= '0;
      end else if (inc) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign expired = (cnt == LIMIT);

endmodule

// File: rtl/mu0_control_unit.sv
// MU0 fetch/execute sequencer: decodes the IR opcode into datapath selects,
// register enables and a memory handshake, with a watchdog on hung accesses.
module mu0_control_unit
   import mu0_pkg::*;
#(
   parameter int TIMEOUT = 15
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] ir_opcode,
   input  logic       acc_zero,
   input  logic       acc_neg,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       mem_rnw,
   output logic       addr_sel,
   output logic       alu_a_sel,
   output logic       alu_b_sel,
   output logic [1:0] alu_fn,
   output logic       acc_ce,
   output logic       pc_ce,
   output logic       ir_ce,
   output logic       acc_oe,
   output logic       halted,
   output logic       fault
);

   logic [1:0] state;
   logic [1:0] next_state;
   ctl_t       ctl;
   logic       expired;
   logic       wait_inc;

   always_comb begin
      ctl         = '0;
      ctl.mem_rnw = 1'b1;
      next_state  = state;
      case (state)
         ST_FETCH: begin
            ctl.mem_req   = 1'b1;
            ctl.alu_a_sel = 1'b1;
            ctl.alu_fn    = ALU_INC_A;
            if (mem_ready) begin
               ctl.ir_ce  = 1'b1;
               ctl.pc_ce  = 1'b1;
               next_state = ST_EXEC;
            end else if (expired) begin
               next_state = ST_FAULT;
            end
         end
         ST_EXEC: begin
            next_state = ST_FETCH;
            case (ir_opcode)
               OP_LDA: begin
                  ctl.mem_req  = 1'b1;
                  ctl.addr_sel = 1'b1;
                  ctl.acc_ce   = mem_ready;
               end
               OP_STO: begin
                  ctl.mem_req  = 1'b1;
                  ctl.mem_rnw  = 1'b0;
                  ctl.addr_sel = 1'b1;
                  ctl.acc_oe   = 1'b1;
               end
               OP_ADD, OP_SUB: begin
                  ctl.mem_req  = 1'b1;
                  ctl.addr_sel = 1'b1;
                  ctl.alu_fn   = (ir_opcode == OP_ADD) ? ALU_ADD : ALU_SUB;
                  ctl.acc_ce   = mem_ready;
               end
               OP_JMP: begin
                  ctl.alu_b_sel = 1'b1;
                  ctl.pc_ce     = 1'b1;
               end
               OP_JGE: begin
                  ctl.alu_b_sel = 1'b1;
                  ctl.pc_ce     = ~acc_neg;
               end
               OP_JNE: begin
                  ctl.alu_b_sel = 1'b1;
                  ctl.pc_ce     = ~acc_zero;
               end
               OP_STP:  next_state = ST_HALT;
               default: ;
            endcase
            // A pending memory op holds EXEC; ready in the expiry cycle still wins.
            if (ctl.mem_req && !mem_ready) begin
               next_state = expired ? ST_FAULT : ST_EXEC;
            end
         end
         ST_HALT:  ctl.halted = 1'b1;
         ST_FAULT: ctl.fault  = 1'b1;
         default:  next_state = ST_FETCH;
      endcase
   end

   // Count only while stalled in the same state; any state change restarts it.
   assign wait_inc = ctl.mem_req & ~mem_ready & (next_state == state);

   mu0_wait_timer #(
      .TIMEOUT(TIMEOUT)
   ) u_wait_timer (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (~wait_inc),
      .inc    (wait_inc),
      .expired(expired)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= ST_FETCH;
      end else begin
         state <= next_state;
      end
   end

   assign mem_req   = rst_n & ctl.mem_req;
   assign mem_rnw   = rst_n & ctl.mem_rnw;
   assign addr_sel  = rst_n & ctl.addr_sel;
   assign alu_a_sel = rst_n & ctl.alu_a_sel;
   assign alu_b_sel = rst_n & ctl.alu_b_sel;
   assign alu_fn    = {2{rst_n}} & ctl.alu_fn;
   assign acc_ce    = rst_n & ctl.acc_ce;
   assign pc_ce     = rst_n & ctl.pc_ce;
   assign ir_ce     = rst_n & ctl.ir_ce;
   assign acc_oe    = rst_n & ctl.acc_oe;
   assign halted    = rst_n & ctl.halted;
   assign fault     = rst_n & ctl.fault;

endmodule

// File: tb/tb_mu0_control_unit.sv
// Directed bench for the MU0 sequencer: drives opcode/flag/ready per cycle and
// compares the whole control bundle against hand-built expected vectors.
module tb_mu0_control_unit;
   import mu0_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] ir_opcode;
   logic       acc_zero;
   logic       acc_neg;
   logic       mem_ready;
   logic       mem_req, mem_rnw, addr_sel, alu_a_sel, alu_b_sel;
   logic [1:0] alu_fn;
   logic       acc_ce, pc_ce, ir_ce, acc_oe, halted, fault;
   logic [12:0] outs;

   int tests  = 0;
   int failed = 0;

   mu0_control_unit #(.TIMEOUT(15)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .ir_opcode(ir_opcode),
      .acc_zero (acc_zero),
      .acc_neg  (acc_neg),
      .mem_ready(mem_ready),
      .mem_req  (mem_req),
      .mem_rnw  (mem_rnw),
      .addr_sel (addr_sel),
      .alu_a_sel(alu_a_sel),
      .alu_b_sel(alu_b_sel),
      .alu_fn   (alu_fn),
      .acc_ce   (acc_ce),
      .pc_ce    (pc_ce),
      .ir_ce    (ir_ce),
      .acc_oe   (acc_oe),
      .halted   (halted),
      .fault    (fault)
   );

   always #5 clk = ~clk;

   assign outs = {mem_req, mem_rnw, addr_sel, alu_a_sel, alu_b_sel, alu_fn,
                  acc_ce, pc_ce, ir_ce, acc_oe, halted, fault};

   // Bit order: req rnw addr a b fn[1:0] acc pc ir oe halt fault
   localparam logic [12:0] V_RST      = 13'b0_0_0_0_0_00_0_0_0_0_0_0;
   localparam logic [12:0] V_FETCH    = 13'b1_1_0_1_0_11_0_1_1_0_0_0;
   localparam logic [12:0] V_FETCH_W  = 13'b1_1_0_1_0_11_0_0_0_0_0_0;
   localparam logic [12:0] V_LDA      = 13'b1_1_1_0_0_00_1_0_0_0_0_0;
   localparam logic [12:0] V_LDA_W    = 13'b1_1_1_0_0_00_0_0_0_0_0_0;
   localparam logic [12:0] V_ADD      = 13'b1_1_1_0_0_01_1_0_0_0_0_0;
   localparam logic [12:0] V_SUB      = 13'b1_1_1_0_0_10_1_0_0_0_0_0;
   localparam logic [12:0] V_STO      = 13'b1_0_1_0_0_00_0_0_0_1_0_0;
   localparam logic [12:0] V_JMP      = 13'b0_1_0_0_1_00_0_1_0_0_0_0;
   localparam logic [12:0] V_JMP_NT   = 13'b0_1_0_0_1_00_0_0_0_0_0_0;
   localparam logic [12:0] V_IDLE     = 13'b0_1_0_0_0_00_0_0_0_0_0_0;
   localparam logic [12:0] V_HALT     = 13'b0_1_0_0_0_00_0_0_0_0_1_0;
   localparam logic [12:0] V_FAULT    = 13'b0_1_0_0_0_00_0_0_0_0_0_1;

   task automatic step(input string tag, input logic rn, input logic [3:0] op,
                       input logic rdy, input logic z, input logic n,
                       input logic [12:0] exp);
      rst_n     = rn;
      ir_opcode = op;
      mem_ready = rdy;
      acc_zero  = z;
      acc_neg   = n;
      @(negedge clk);
      tests++;
      assert (outs === exp) else begin
         failed++;
         $error("FAIL %s: got %b expected %b", tag, outs, exp);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      // reset held 3 cycles with ready high: every output low
      for (int i = 0; i < 3; i++) step("reset_hold", 1'b0, OP_LDA, 1'b1, 1'b0, 1'b0, V_RST);

      // LDA / ADD / STO / STP program, no wait states
      step("fetch_lda", 1'b1, OP_LDA, 1'b1, 1'b0, 1'b0, V_FETCH);
      step("exec_lda",  1'b1, OP_LDA, 1'b1, 1'b0, 1'b0, V_LDA);
      step("fetch_add", 1'b1, OP_ADD, 1'b1, 1'b0, 1'b0, V_FETCH);
      step("exec_add",  1'b1, OP_ADD, 1'b1, 1'b0, 1'b0, V_ADD);
      step("fetch_sub", 1'b1, OP_SUB, 1'b1, 1'b0, 1'b0, V_FETCH);
      step("exec_sub",  1'b1, OP_SUB, 1'b1, 1'b0, 1'b0, V_SUB);
      step("fetch_sto", 1'b1, OP_STO, 1'b1, 1'b0, 1'b0, V_FETCH);
      step("exec_sto",  1'b1, OP_STO, 1'b1, 1'b0, 1'b0, V_STO);
      step("fetch_stp", 1'b1, OP_STP, 1'b1, 1'b0, 1'b0, V_FETCH);
      step("exec_stp",  1'b1, OP_STP, 1'b1, 1'b0, 1'b0, V_IDLE);
      step("halt_0",    1'b1, OP_LDA, 1'b1, 1'b0, 1'b0, V_HALT);
      step("halt_1",    1'b1, OP_LDA, 1'b1, 1'b0, 1'b0, V_HALT);

      // conditional jumps and JMP, single EXEC cycle each
      step("reset_j",   1'b0, OP_JGE, 1'b1, 1'b0, 1'b1, V_RST);
      step("fetch_jge", 1'b1, OP_JGE, 1'b1, 1'b0, 1'b1, V_FETCH);
      step("exec_jge",  1'b1, OP_JGE, 1'b1, 1'b0, 1'b1, V_JMP_NT);
      step("fetch_jne", 1'b1, OP_JNE, 1'b1, 1'b0, 1'b0, V_FETCH);
      step("exec_jne",  1'b1, OP_JNE, 1'b1, 1'b0, 1'b0, V_JMP);
      step("fetch_jne2",1'b1, OP_JNE, 1'b1, 1'b1, 1'b0, V_FETCH);
      step("exec_jne_z",1'b1, OP_JNE, 1'b1, 1'b1, 1'b0, V_JMP_NT);
      step("fetch_jmp", 1'b1, OP_JMP, 1'b1, 1'b1, 1'b1, V_FETCH);
      step("exec_jmp",  1'b1, OP_JMP, 1'b0, 1'b1, 1'b1, V_JMP);

      // LDA with three wait states
      step("fetch_ldaw", 1'b1, OP_LDA, 1'b1, 1'b0, 1'b0, V_FETCH);
      for (int i = 0; i < 3; i++) step("exec_lda_wait", 1'b1, OP_LDA, 1'b0, 1'b0, 1'b0, V_LDA_W);
      step("exec_lda_done", 1'b1, OP_LDA, 1'b1, 1'b0, 1'b0, V_LDA);

      // NOP opcode 0xA
      step("fetch_nop", 1'b1, 4'hA, 1'b1, 1'b0, 1'b0, V_FETCH);
      step("exec_nop",  1'b1, 4'hA, 1'b1, 1'b0, 1'b0, V_IDLE);

      // watchdog: 16 unanswered FETCH cycles, then sticky FAULT
      for (int i = 0; i < 16; i++) step("fetch_hang", 1'b1, OP_LDA, 1'b0, 1'b0, 1'b0, V_FETCH_W);
      step("fault_0", 1'b1, OP_LDA, 1'b1, 1'b0, 1'b0, V_FAULT);
      step("fault_1", 1'b1, OP_LDA, 1'b1, 1'b0, 1'b0, V_FAULT);

      // ready on the 16th cycle beats the timeout
      step("reset_t", 1'b0, OP_LDA, 1'b0, 1'b0, 1'b0, V_RST);
      for (int i = 0; i < 15; i++) step("fetch_slow", 1'b1, 4'hB, 1'b0, 1'b0, 1'b0, V_FETCH_W);
      step("fetch_late_rdy", 1'b1, 4'hB, 1'b1, 1'b0, 1'b0, V_FETCH);
      step("exec_after_late", 1'b1, 4'hB, 1'b1, 1'b0, 1'b0, V_IDLE);

      // reset during a waiting LDA restarts in FETCH
      step("fetch_ldar", 1'b1, OP_LDA, 1'b1, 1'b0, 1'b0, V_FETCH);
      step("exec_ldar_w0", 1'b1, OP_LDA, 1'b0, 1'b0, 1'b0, V_LDA_W);
      step("exec_ldar_w1", 1'b1, OP_LDA, 1'b0, 1'b0, 1'b0, V_LDA_W);
      step("reset_mid",    1'b0, OP_LDA, 1'b0, 1'b0, 1'b0, V_RST);
      step("fetch_restart",1'b1, OP_LDA, 1'b0, 1'b0, 1'b0, V_FETCH_W);
      step("fetch_restart_rdy", 1'b1, OP_LDA, 1'b1, 1'b0, 1'b0, V_FETCH);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
